regbank_write_ctrl: RTL and testbench

Controller that shares one bank of NUM_REGS 20-bit register_word storage cells between two write requesters: the ALU writeback (port 0) and the load unit (port 1). It arbitrates the requesters round-robin, decodes the granted address into per-register WE strobes, and serves two read ports. A valid scoreboard makes never-written registers read as zero after reset. It sits between the execute/load stages and the register storage.

---
 rtl/urcpu_pkg.sv | 18 +
 rtl/regbank_write_ctrl_if.sv | 40 ++++
 rtl/register_word.sv | 19 +
 rtl/rr_arbiter2.sv | 46 ++++
 rtl/regbank_write_ctrl.sv | 105 ++++++++++
 tb/tb_regbank_write_ctrl.sv | 234 +++++++++++++++++++++++
 6 files changed

// File: rtl/urcpu_pkg.sv
// Shared types and default sizing for the register bank and its write controller.
// Contents: WORD_W, default bank size/address width, word/address typedefs,
// requester identifiers.
package urcpu_pkg;

    localparam int unsigned WORD_W       = 20;
    localparam int unsigned DEF_NUM_REGS = 8;
    localparam int unsigned DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_t;

endpackage : urcpu_pkg

// File: rtl/regbank_write_ctrl_if.sv
// Bus bundle between the execute/load requesters and the register bank controller.
// Signals: two valid/ready write request channels (addr, data) and two read
// ports (addr in, data out).
// Modports: master = requester/reader side, slave = controller side.
interface regbank_write_ctrl_if
    import urcpu_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    word_t             req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    word_t             req1_data;
    logic              req1_ready;

    logic [ADDR_W-1:0] rd_addr_a;
    word_t             rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    word_t             rd_data_b;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output rd_addr_a, rd_addr_b,
        input  req0_ready, req1_ready, rd_data_a, rd_data_b
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  rd_addr_a, rd_addr_b,
        output req0_ready, req1_ready, rd_data_a, rd_data_b
    );

endinterface : regbank_write_ctrl_if

// File: rtl/register_word.sv
// One WORD_W-bit storage cell with write enable. No reset: contents are only
// meaningful once the owning controller has marked the cell valid.
// Ports: clk, we (write strobe), d (write data), q (stored word).
module register_word
    import urcpu_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  word_t d,
    output word_t q
);

    always_ff @(posedge clk) begin
        if (we) begin
            q <= d;
        end
    end

endmodule : register_word

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Holds the only arbitration state: a
// priority pointer that moves to the losing side after every grant and is
// left alone on idle or disabled cycles.
// Ports: clk, rst_n, en (grant enable), req[1:0], gnt_c[1:0] (combinational one-hot).
module rr_arbiter2
    import urcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    req_id_t ptr_q;
    req_id_t ptr_d;

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grant selection and pointer advance
    always_comb begin
        gnt_c = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            unique case (req)
                2'b01:   gnt_c = 2'b01;
                2'b10:   gnt_c = 2'b10;
                2'b11:   gnt_c = (ptr_q == REQ_ALU) ? 2'b01 : 2'b10;
                default: gnt_c = 2'b00;
            endcase
        end
        if (gnt_c[0]) begin
            ptr_d = REQ_LOAD;
        end else if (gnt_c[1]) begin
            ptr_d = REQ_ALU;
        end
    end

endmodule : rr_arbiter2

// File: rtl/regbank_write_ctrl.sv
// Write/read controller for a bank of NUM_REGS register_word cells shared by
// the ALU writeback (port 0) and the load unit (port 1). Arbitrates writes
// round-robin, decodes the granted address into one WE strobe, tracks a valid
// bitmap so never-written cells read as zero, and serves two combinational
// read ports.
// Ports: clk, rst_n (async active-low), clr_all (sync valid clear),
//        bus (slave modport: req0/req1 valid/addr/data/ready, rd_addr_a/b, rd_data_a/b).
// Config: define REGBANK_BYPASS_EN to forward the granted write data to a read
//         port addressing the same register in the same cycle.
module regbank_write_ctrl
    import urcpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_all,
    regbank_write_ctrl_if.slave  bus
);

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                arb_en;
    logic                wr_en;
    logic                wr_in_range;
    logic [ADDR_W-1:0]   wr_addr;
    word_t               wr_data;
    logic [NUM_REGS-1:0] we;
    logic [NUM_REGS-1:0] valid_q;
    word_t               q [NUM_REGS];
    logic [ADDR_W-1:0]   rd_addr [2];
    word_t               rd_data [2];

    assign req    = {bus.req1_valid, bus.req0_valid};
    // Ready must read 0 while reset is asserted, so rst_n gates the grant directly.
    assign arb_en = rst_n & ~clr_all;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (req),
        .gnt_c (gnt)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    // Granted write channel mux
    assign wr_en       = |gnt;
    assign wr_addr     = gnt[1] ? bus.req1_addr : bus.req0_addr;
    assign wr_data     = gnt[1] ? bus.req1_data : bus.req0_data;
    assign wr_in_range = 32'(wr_addr) < NUM_REGS;

    // One-hot WE decode; out-of-range addresses are accepted but dropped
    always_comb begin
        we = '0;
        if (wr_en && wr_in_range) begin
            we[wr_addr] = 1'b1;
        end
    end

    // Valid scoreboard; clear wins over a same-cycle write (none is granted anyway)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_q | we;
        end
    end

    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_regs
        register_word u_word (
            .clk (clk),
            .we  (we[i]),
            .d   (wr_data),
            .q   (q[i])
        );
    end

    assign rd_addr[0] = bus.rd_addr_a;
    assign rd_addr[1] = bus.rd_addr_b;

    // Read ports: invalid or out-of-range cells read as zero
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if ((32'(rd_addr[p]) < NUM_REGS) && valid_q[rd_addr[p]]) begin
                rd_data[p] = q[rd_addr[p]];
            end
`ifdef REGBANK_BYPASS_EN
            if (wr_en && wr_in_range && (wr_addr == rd_addr[p])) begin
                rd_data[p] = wr_data;
            end
`endif
        end
    end

    assign bus.rd_data_a = rd_data[0];
    assign bus.rd_data_b = rd_data[1];

endmodule : regbank_write_ctrl

// File: tb/tb_regbank_write_ctrl.sv
// Self-checking bench for regbank_write_ctrl: reset checks, a directed vector
// table, asynchronous reset mid-operation, and a randomized phase compared
// against a behavioural register-file model.
module tb_regbank_write_ctrl;
    import urcpu_pkg::*;

    localparam int unsigned NR = DEF_NUM_REGS;
    localparam int unsigned AW = DEF_ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_all = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regbank_write_ctrl_if #(.ADDR_W(AW)) bus ();

    regbank_write_ctrl #(.NUM_REGS(NR), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_all (clr_all),
        .bus     (bus.slave)
    );

    typedef struct {
        logic          clr;
        logic          v0;
        logic [AW-1:0] a0;
        word_t         d0;
        logic          v1;
        logic [AW-1:0] a1;
        word_t         d1;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic          r0;
        logic          r1;
        word_t         ea;
        word_t         eb;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state
    word_t m_mem [NR];
    bit    m_val [NR];
    int    m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic clr,
                                input logic v0, input int a0, input int d0,
                                input logic v1, input int a1, input int d1,
                                input int ra, input int rb,
                                input logic r0, input logic r1,
                                input int ea, input int eb);
        vec_t v;
        v.clr = clr;
        v.v0 = v0; v.a0 = AW'(a0); v.d0 = WORD_W'(d0);
        v.v1 = v1; v.a1 = AW'(a1); v.d1 = WORD_W'(d1);
        v.ra = AW'(ra); v.rb = AW'(rb);
        v.r0 = r0; v.r1 = r1;
        v.ea = WORD_W'(ea); v.eb = WORD_W'(eb);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        clr_all        = v.clr;
        bus.req0_valid = v.v0;
        bus.req0_addr  = v.a0;
        bus.req0_data  = v.d0;
        bus.req1_valid = v.v1;
        bus.req1_addr  = v.a1;
        bus.req1_data  = v.d1;
        bus.rd_addr_a  = v.ra;
        bus.rd_addr_b  = v.rb;
    endtask

    function automatic word_t m_read(input logic [AW-1:0] a, input bit g,
                                     input logic [AW-1:0] ga, input word_t gd);
`ifdef REGBANK_BYPASS_EN
        if (g && (ga == a)) return gd;
`endif
        return m_val[a] ? m_mem[a] : '0;
    endfunction

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t byp_eb;
        bit    p0_v, p1_v, c;
        logic [AW-1:0] p0_a, p1_a, ra, rb;
        word_t p0_d, p1_d;
        int g;

`ifdef REGBANK_BYPASS_EN
        byp_eb = 20'h0F0F0;
`else
        byp_eb = 20'h00000;
`endif

        // Reset: requests asserted but ready must stay low
        apply(mk(0, 1, 3, 'h1, 1, 4, 'h2, 3, 4, 0, 0, 0, 0));
        #12;
        chk("rst_ready0", 32'(bus.req0_ready), 0);
        chk("rst_ready1", 32'(bus.req1_ready), 0);
        chk("rst_rd_a", 32'(bus.rd_data_a), 0);
        chk("rst_rd_b", 32'(bus.rd_data_b), 0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All addresses read zero after reset
        for (int i = 0; i < int'(NR); i++) begin
            bus.rd_addr_a = AW'(i);
            bus.rd_addr_b = AW'(NR - 1 - i);
            #1;
            chk($sformatf("post_rst_a[%0d]", i), 32'(bus.rd_data_a), 0);
            chk($sformatf("post_rst_b[%0d]", NR - 1 - i), 32'(bus.rd_data_b), 0);
        end

        // Directed table, pointer starts at port 0
        //                 clr v0 a0 d0       v1 a1 d1       ra rb r0 r1 ea       eb
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 7, 0, 0, 0,       0));
        tbl.push_back(mk(0, 1, 3, 'hABCDE,  0, 0, 0,        2, 1, 1, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        3, 1, 0, 0, 'hABCDE, 0));
        tbl.push_back(mk(0, 0, 0, 0,        1, 0, 'h00777,  3, 3, 0, 1, 'hABCDE, 'hABCDE));
        tbl.push_back(mk(0, 1, 1, 'h11111,  1, 2, 'h22222,  1, 2, 1, 0, 0,       0));
        tbl.push_back(mk(0, 1, 1, 'h11111,  1, 2, 'h22222,  1, 2, 0, 1, 'h11111, 0));
        tbl.push_back(mk(0, 1, 1, 'h11111,  1, 2, 'h22222,  1, 2, 1, 0, 'h11111, 'h22222));
        tbl.push_back(mk(0, 1, 1, 'h11111,  1, 2, 'h22222,  1, 2, 0, 1, 'h11111, 'h22222));
        tbl.push_back(mk(0, 1, 5, 'h00001,  1, 5, 'h00002,  5, 0, 1, 0, 0,       'h00777));
        tbl.push_back(mk(0, 0, 0, 0,        1, 5, 'h00002,  5, 0, 0, 1, 'h00001, 'h00777));
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        5, 3, 0, 0, 'h00002, 'hABCDE));
        tbl.push_back(mk(0, 1, 4, 'h12345,  0, 0, 0,        4, 0, 1, 0, 0,       'h00777));
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        4, 0, 0, 0, 'h12345, 'h00777));
        tbl.push_back(mk(1, 0, 0, 0,        1, 6, 'h0F0F0,  4, 6, 0, 0, 'h12345, 0));
        tbl.push_back(mk(0, 0, 0, 0,        1, 6, 'h0F0F0,  4, 3, 0, 1, 0,       0));
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        4, 6, 0, 0, 0,       'h0F0F0));
        tbl.push_back(mk(1, 0, 0, 0,        0, 0, 0,        6, 6, 0, 0, 'h0F0F0, 'h0F0F0));
        tbl.push_back(mk(0, 1, 6, 'h0F0F0,  0, 0, 0,        0, 6, 1, 0, 0,       int'(byp_eb)));
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 6, 0, 0, 0,       'h0F0F0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready0", i), 32'(bus.req0_ready), 32'(tbl[i].r0));
            chk($sformatf("tbl%0d_ready1", i), 32'(bus.req1_ready), 32'(tbl[i].r1));
            chk($sformatf("tbl%0d_rd_a", i), 32'(bus.rd_data_a), 32'(tbl[i].ea));
            chk($sformatf("tbl%0d_rd_b", i), 32'(bus.rd_data_b), 32'(tbl[i].eb));
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-operation: r6 valid, both ports requesting
        apply(mk(0, 1, 2, 'h3, 1, 3, 'h4, 6, 6, 0, 0, 0, 0));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready0", 32'(bus.req0_ready), 0);
        chk("midrst_ready1", 32'(bus.req1_ready), 0);
        chk("midrst_rd_a", 32'(bus.rd_data_a), 0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized phase against the model
        for (int i = 0; i < int'(NR); i++) begin
            m_val[i] = 1'b0;
            m_mem[i] = '0;
        end
        m_ptr = 0;
        p0_v = 0; p1_v = 0;
        p0_a = '0; p1_a = '0; p0_d = '0; p1_d = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (!p0_v && ($urandom_range(0, 2) != 0)) begin
                p0_v = 1; p0_a = AW'($urandom_range(0, NR - 1)); p0_d = WORD_W'($urandom);
            end
            if (!p1_v && ($urandom_range(0, 2) != 0)) begin
                p1_v = 1; p1_a = AW'($urandom_range(0, NR - 1)); p1_d = WORD_W'($urandom);
            end
            c  = ($urandom_range(0, 15) == 0);
            ra = AW'($urandom_range(0, NR - 1));
            rb = (cyc % 3 == 0) ? p0_a : AW'($urandom_range(0, NR - 1));
            clr_all        = c;
            bus.req0_valid = p0_v; bus.req0_addr = p0_a; bus.req0_data = p0_d;
            bus.req1_valid = p1_v; bus.req1_addr = p1_a; bus.req1_data = p1_d;
            bus.rd_addr_a  = ra;   bus.rd_addr_b = rb;

            g = -1;
            if (!c) begin
                if (p0_v && p1_v) g = m_ptr;
                else if (p0_v)    g = 0;
                else if (p1_v)    g = 1;
            end

            @(negedge clk);
            chk("rnd_ready0", 32'(bus.req0_ready), 32'(g == 0));
            chk("rnd_ready1", 32'(bus.req1_ready), 32'(g == 1));
            chk("rnd_rd_a", 32'(bus.rd_data_a),
                32'(m_read(ra, g >= 0, (g == 1) ? p1_a : p0_a, (g == 1) ? p1_d : p0_d)));
            chk("rnd_rd_b", 32'(bus.rd_data_b),
                32'(m_read(rb, g >= 0, (g == 1) ? p1_a : p0_a, (g == 1) ? p1_d : p0_d)));
            @(posedge clk); #1;

            if (c) begin
                for (int i = 0; i < int'(NR); i++) m_val[i] = 1'b0;
            end else if (g == 0) begin
                m_mem[p0_a] = p0_d; m_val[p0_a] = 1'b1; p0_v = 0; m_ptr = 1;
            end else if (g == 1) begin
                m_mem[p1_a] = p1_d; m_val[p1_a] = 1'b1; p1_v = 0; m_ptr = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regbank_write_ctrl
